// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared mode encoding for the multi-channel tick generator
package tick_gen_pkg;
  typedef enum logic [1:0] {TM_OFF, TM_PULSE, TM_TOGGLE, TM_ONESHOT} tick_mode_e;
  localparam tick_mode_e TM_RESET = TM_TOGGLE;
endpackage

// File: rtl/tick_chan.sv
// tick_chan: one programmable tick channel (counter, divisor, mode, registered outputs)
module tick_chan
  import tick_gen_pkg::*;
#(
  parameter int          CNT_W       = 32,
  parameter int unsigned DEFAULT_DIV = 6000000
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ld,
  input  logic [CNT_W-1:0] ld_div,
  input  tick_mode_e       ld_mode,
  output logic             pulse,
  output logic             level,
  output logic             busy
);
  logic [CNT_W-1:0] cnt, div;
  tick_mode_e       mode;
  // A load restarts the channel and takes priority over a coincident terminal count
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt   <= '0;
      div   <= CNT_W'(DEFAULT_DIV);
      mode  <= TM_RESET;
      pulse <= 1'b0;
      level <= 1'b0;
      busy  <= 1'b0;
    end else if (ld) begin
      cnt   <= '0;
      div   <= ld_div;
      mode  <= ld_mode;
      pulse <= 1'b0;
      level <= 1'b0;
      busy  <= ld_mode != TM_OFF;
    end else if (mode == TM_OFF) begin
      cnt   <= '0;
      pulse <= 1'b0;
      busy  <= 1'b0;
    end else if (cnt == div) begin
      cnt   <= '0;
      pulse <= 1'b1;
      level <= (mode == TM_TOGGLE) ? ~level : (mode == TM_ONESHOT);
      mode  <= (mode == TM_ONESHOT) ? TM_OFF : mode;
      busy  <= mode != TM_ONESHOT;
    end else begin
      cnt   <= cnt + 1'b1;
      pulse <= 1'b0;
      busy  <= 1'b1;
    end
  end
endmodule

// File: rtl/tick_gen_multi.sv
// tick_gen_multi: NUM_CH independent tick channels behind a single config write port
module tick_gen_multi
  import tick_gen_pkg::*;
#(
  parameter int          NUM_CH      = 4,
  parameter int          CNT_W       = 32,
  parameter int unsigned DEFAULT_DIV = 6000000,
  localparam int         CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [1:0]        cfg_mode,
  output logic [NUM_CH-1:0] tick_pulse,
  output logic [NUM_CH-1:0] tick_level,
  output logic [NUM_CH-1:0] busy
);
  logic acc;
  assign acc = cfg_valid & cfg_ready;
  always_ff @(posedge clk) cfg_ready <= rstn;
  // Out-of-range channel indices match no instance, so such writes are silently dropped
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tick_chan #(.CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) u_chan (
      .clk    (clk),
      .rstn   (rstn),
      .ld     (acc && cfg_ch == CH_W'(i)),
      .ld_div (cfg_div),
      .ld_mode(tick_mode_e'(cfg_mode)),
      .pulse  (tick_pulse[i]),
      .level  (tick_level[i]),
      .busy   (busy[i])
    );
  end
endmodule

// File: tb/tb_tick_gen_multi.sv
// tb_tick_gen_multi: randomized check of a 4-channel and a 3-channel build against a closed-form model
module tb_tick_gen_multi;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [31:0] cfg_div = '0;
  logic [1:0]  cfg_mode = '0;
  logic        rdy_a, rdy_b;
  logic [3:0]  pulse_a, level_a, busy_a;
  logic [2:0]  pulse_b, level_b, busy_b;
  int tests = 0, fails = 0, n = 0;
  int st[2][4], dv[2][4], md[2][4];
  bit rs[2][4];
  bit rdy[2];

  always #5 clk = ~clk;

  tick_gen_multi #(.NUM_CH(4), .CNT_W(32), .DEFAULT_DIV(3)) u_a (
    .clk(clk), .rstn(rstn), .cfg_valid(cfg_valid), .cfg_ready(rdy_a), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_mode(cfg_mode), .tick_pulse(pulse_a), .tick_level(level_a), .busy(busy_a)
  );
  tick_gen_multi #(.NUM_CH(3), .CNT_W(8), .DEFAULT_DIV(3)) u_b (
    .clk(clk), .rstn(rstn), .cfg_valid(cfg_valid), .cfg_ready(rdy_b), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div[7:0]), .cfg_mode(cfg_mode), .tick_pulse(pulse_b), .tick_level(level_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %h expected %h", tag, n, got, exp);
    end
  endtask

  // {pulse, level, busy} after edge m for a channel (re)started at edge s
  function automatic logic [2:0] ref_out(input int d, input int mo, input int s, input bit r, input int m);
    int k = m - s;
    int p = d + 1;
    if (k == 0) return {2'b00, !r && mo != 0};
    case (mo)
      0:       return 3'b000;
      1:       return {k % p == 0, 1'b0, 1'b1};
      2:       return {k % p == 0, (k / p) % 2 == 1, 1'b1};
      default: return {k == p, k >= p, k < p};
    endcase
  endfunction

  task automatic cyc(input bit r, input bit v, input logic [1:0] c, input int d, input int mo);
    logic [3:0] ep[2], el[2], eb[2];
    logic [2:0] o;
    rstn = r; cfg_valid = v; cfg_ch = c; cfg_div = d; cfg_mode = 2'(mo);
    @(posedge clk);
    n++;
    for (int k = 0; k < 2; k++) begin
      if (!r) begin
        for (int ch = 0; ch < 4; ch++) begin
          st[k][ch] = n; dv[k][ch] = 3; md[k][ch] = 2; rs[k][ch] = 1'b1;
        end
      end else if (v && rdy[k] && int'(c) < (k == 0 ? 4 : 3)) begin
        st[k][c] = n; dv[k][c] = d; md[k][c] = mo; rs[k][c] = 1'b0;
      end
      rdy[k] = r;
      ep[k] = '0; el[k] = '0; eb[k] = '0;
      for (int ch = 0; ch < 4; ch++) begin
        o = ref_out(dv[k][ch], md[k][ch], st[k][ch], rs[k][ch], n);
        {ep[k][ch], el[k][ch], eb[k][ch]} = o;
      end
    end
    @(negedge clk);
    check("ready_a", 32'(rdy_a), 32'(rdy[0]));
    check("pulse_a", 32'(pulse_a), 32'(ep[0]));
    check("level_a", 32'(level_a), 32'(el[0]));
    check("busy_a", 32'(busy_a), 32'(eb[0]));
    check("ready_b", 32'(rdy_b), 32'(rdy[1]));
    check("pulse_b", 32'(pulse_b), 32'(ep[1][2:0]));
    check("level_b", 32'(level_b), 32'(el[1][2:0]));
    check("busy_b", 32'(busy_b), 32'(eb[1][2:0]));
  endtask

  task automatic idle(input int cnt);
    for (int i = 0; i < cnt; i++) cyc(1'b1, 1'b0, 2'd0, 0, 0);
  endtask

  initial begin
    @(negedge clk);
    cyc(1'b0, 1'b1, 2'd1, 7, 1);
    cyc(1'b0, 1'b0, 2'd0, 0, 0);
    cyc(1'b1, 1'b1, 2'd1, 0, 1);
    idle(12);
    cyc(1'b1, 1'b1, 2'd1, 0, 1);
    idle(6);
    cyc(1'b1, 1'b1, 2'd2, 5, 3);
    idle(55);
    for (int i = 0; i < 4 && ((n + 1 - st[0][0]) % 4) != 0; i++) idle(1);
    cyc(1'b1, 1'b1, 2'd0, 3, 2);
    idle(9);
    cyc(1'b1, 1'b1, 2'd3, 4, 1);
    idle(5);
    cyc(1'b1, 1'b1, 2'd3, 2, 0);
    idle(3);
    cyc(1'b0, 1'b1, 2'd2, 1, 3);
    idle(10);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(99) != 0, $urandom_range(4) == 0, 2'($urandom_range(3)),
          int'($urandom_range(9)), int'($urandom_range(3)));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
